code_ram_arbiter: RTL and testbench

//  Shares the single-port 32-bit code RAM between the CPU instruction-fetch port (read-only)
//  and the CPU data port (read/write, byte-enabled). Fixed priority to data, starvation guard
//  for fetch. Routes the 1-cycle-latency read data back to the owning requester.

---
 rtl/code_ram_arb_pkg.sv | 23 ++
 rtl/arb_starve_ctr.sv | 39 +++
 rtl/code_ram_arbiter.sv | 145 ++++++++++++++
 tb/tb_code_ram_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/code_ram_arb_pkg.sv
// Shared types and constants for the code RAM arbiter.
package code_ram_arb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 4;

  localparam logic [DATA_W-1:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    NONE      = 3'd0,
    RD_IF     = 3'd1,
    RD_D      = 3'd2,
    RD_OOB_IF = 3'd3,
    RD_OOB_D  = 3'd4
  } owner_t;

  // True when a word address falls inside the implemented RAM.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive denied fetch cycles; sat_o raises fetch priority.
module arb_starve_ctr
  import code_ram_arb_pkg::*;
#(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_W'(LIMIT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    sat_d = (cnt_d == CNT_W'(LIMIT));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign sat_o = sat_q;

endmodule

// File: rtl/code_ram_arbiter.sv
// Shares the single-port code RAM between instruction fetch and the data port;
// data has priority except when fetch has been starved for STARVE_LIMIT cycles.
module code_ram_arbiter
  import code_ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DEPTH        = 40000,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter bit          WRITE_EN     = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_read,
  input  logic [ADDR_W-1:0] if_address,
  output logic              if_waitrequest,
  output logic [DATA_W-1:0] if_readdata,
  output logic              if_readdatavalid,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [BE_W-1:0]   d_byteenable,
  input  logic [DATA_W-1:0] d_writedata,
  output logic              d_waitrequest,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_readdatavalid,
  output logic              d_error,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic              ram_debugaccess,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  logic   d_req, fetch_prio, grant_if, grant_d;
  logic   if_inrange, d_inrange, d_wr_ok;
  owner_t owner_q, owner_d;
  logic   d_error_q, d_error_d;

  // Combinational grant: one RAM access per cycle.
  assign d_req          = d_read | d_write;
  assign grant_if       = if_read & (fetch_prio | ~d_req);
  assign grant_d        = d_req & ~grant_if;
  assign if_waitrequest = if_read & ~grant_if;
  assign d_waitrequest  = d_req & ~grant_d;

  assign if_inrange = addr_in_range(32'(if_address), DEPTH);
  assign d_inrange  = addr_in_range(32'(d_address), DEPTH);
  assign d_wr_ok    = d_inrange & WRITE_EN;

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (if_waitrequest),
    .clr_i   (grant_if | ~if_read),
    .sat_o   (fetch_prio)
  );

  // RAM request mux; a simultaneous read+write from the data port is a write.
  always_comb begin
    ram_address    = d_address;
    ram_byteenable = 4'hF;
    ram_chipselect = 1'b0;
    ram_write      = 1'b0;
    if (grant_if) begin
      ram_address    = if_address;
      ram_chipselect = if_inrange;
    end else if (grant_d) begin
      if (d_write) begin
        ram_byteenable = d_byteenable;
        ram_chipselect = d_wr_ok;
        ram_write      = d_wr_ok;
      end else begin
        ram_chipselect = d_inrange;
      end
    end
  end

  assign ram_debugaccess = ram_write;
  assign ram_writedata   = d_writedata;
  assign ram_clken       = 1'b1;

  // Owner of next cycle's read beat, plus the data-port error pulse.
  always_comb begin
    owner_d   = NONE;
    d_error_d = 1'b0;
    if (grant_if) begin
      owner_d = if_inrange ? RD_IF : RD_OOB_IF;
    end else if (grant_d) begin
      if (d_write) begin
        d_error_d = ~d_wr_ok;
      end else begin
        owner_d   = d_inrange ? RD_D : RD_OOB_D;
        d_error_d = ~d_inrange;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q   <= NONE;
      d_error_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      d_error_q <= d_error_d;
    end
  end

  assign d_error = d_error_q;

  // Response demux: RAM data is valid one cycle after the accepted read.
  always_comb begin
    if_readdatavalid = 1'b0;
    if_readdata      = '0;
    d_readdatavalid  = 1'b0;
    d_readdata       = '0;
    case (owner_q)
      RD_IF: begin
        if_readdatavalid = 1'b1;
        if_readdata      = ram_readdata;
      end
      RD_OOB_IF: begin
        if_readdatavalid = 1'b1;
        if_readdata      = RV_NOP;
      end
      RD_D: begin
        d_readdatavalid = 1'b1;
        d_readdata      = ram_readdata;
      end
      RD_OOB_D: begin
        d_readdatavalid = 1'b1;
      end
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  a_no_rd_wr: assert property (@(posedge clk) disable iff (!reset_n) !(d_read && d_write));
`endif

endmodule

// File: tb/tb_code_ram_arbiter.sv
// Directed bench for code_ram_arbiter: vector table plus arbitration/reset sequences.
module tb_code_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_read, if_waitrequest, if_readdatavalid;
  logic [15:0] if_address;
  logic [31:0] if_readdata;
  logic        d_read, d_write, d_waitrequest, d_readdatavalid, d_error;
  logic [15:0] d_address;
  logic [3:0]  d_byteenable;
  logic [31:0] d_writedata, d_readdata;
  logic [15:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_debugaccess, ram_clken;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata = 32'h0;

  logic [31:0] mem [0:65535];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  code_ram_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .if_read(if_read), .if_address(if_address), .if_waitrequest(if_waitrequest),
    .if_readdata(if_readdata), .if_readdatavalid(if_readdatavalid),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_byteenable(d_byteenable),
    .d_writedata(d_writedata), .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .d_readdatavalid(d_readdatavalid), .d_error(d_error),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_debugaccess(ram_debugaccess), .ram_writedata(ram_writedata),
    .ram_clken(ram_clken), .ram_readdata(ram_readdata)
  );

  // Single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
      end else begin
        ram_readdata <= mem[ram_address];
      end
    end
  end

  typedef struct {
    logic        ir;
    logic [15:0] ia;
    logic        dr, dw;
    logic [15:0] da;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        eiw, edw, eirv;
    logic [31:0] eird;
    logic        edrv;
    logic [31:0] edrd;
    logic        eerr, ecs, ewr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add_v(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                       input logic [15:0] da, input logic [3:0] be, input logic [31:0] wd,
                       input logic eiw, input logic edw, input logic eirv, input logic [31:0] eird,
                       input logic edrv, input logic [31:0] edrd, input logic eerr,
                       input logic ecs, input logic ewr);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.be = be; v.wd = wd;
    v.eiw = eiw; v.edw = edw; v.eirv = eirv; v.eird = eird; v.edrv = edrv; v.edrd = edrd;
    v.eerr = eerr; v.ecs = ecs; v.ewr = ewr;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                       input logic [15:0] da, input logic [3:0] be, input logic [31:0] wd);
    if_read = ir; if_address = ia; d_read = dr; d_write = dw;
    d_address = da; d_byteenable = be; d_writedata = wd;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = {16'hC0DE, 16'(i)};
    reset_n = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);

    // idle
    add_v(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    // fetch-only back-to-back 0..7
    for (int a = 0; a < 8; a++)
      add_v(1, 16'(a), 0, 0, 0, 0, 0,  0, 0, a > 0, (a > 0) ? {16'hC0DE, 16'(a - 1)} : 32'h0,
            0, 0, 0, 1, 0);
    add_v(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 32'hC0DE0007, 0, 0, 0, 0, 0);
    // partial write then read back
    add_v(0, 0, 0, 1, 16'h10, 4'b0011, 32'hDEADBEEF,  0, 0, 0, 0, 0, 0, 0, 1, 1);
    add_v(0, 0, 1, 0, 16'h10, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0);
    add_v(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 32'hC0DEBEEF, 0, 0, 0);
    // alternating owners
    add_v(1, 16'd1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0);
    add_v(0, 0, 1, 0, 16'd2, 0, 0,  0, 0, 1, 32'hC0DE0001, 0, 0, 0, 1, 0);
    add_v(1, 16'd3, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 32'hC0DE0002, 0, 1, 0);
    add_v(0, 0, 1, 0, 16'd4, 0, 0,  0, 0, 1, 32'hC0DE0003, 0, 0, 0, 1, 0);
    add_v(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 32'hC0DE0004, 0, 0, 0);
    // out-of-range reads and write
    add_v(0, 0, 1, 0, 16'd40000, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_v(1, 16'd40000, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 32'h0, 1, 0, 0);
    add_v(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 32'h00000013, 0, 0, 0, 0, 0);
    add_v(0, 0, 0, 1, 16'd40001, 4'hF, 32'h12345678,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_v(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0);
    add_v(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    // last in-range word
    add_v(0, 0, 1, 0, 16'd39999, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0);
    add_v(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 32'hC0DE9C3F, 0, 0, 0);

    // reset state
    @(negedge clk); #1;
    chk("rst_if_rdv", 32'(if_readdatavalid), 32'h0);
    chk("rst_d_rdv", 32'(d_readdatavalid), 32'h0);
    chk("rst_d_err", 32'(d_error), 32'h0);
    chk("rst_cs", 32'(ram_chipselect), 32'h0);
    chk("rst_wr", 32'(ram_write), 32'h0);
    chk("rst_waits", {30'h0, if_waitrequest, d_waitrequest}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].ir, vecs[k].ia, vecs[k].dr, vecs[k].dw, vecs[k].da, vecs[k].be, vecs[k].wd);
      #1;
      chk($sformatf("v%0d_if_wait", k), 32'(if_waitrequest), 32'(vecs[k].eiw));
      chk($sformatf("v%0d_d_wait", k), 32'(d_waitrequest), 32'(vecs[k].edw));
      chk($sformatf("v%0d_if_rdv", k), 32'(if_readdatavalid), 32'(vecs[k].eirv));
      chk($sformatf("v%0d_if_rd", k), if_readdata, vecs[k].eird);
      chk($sformatf("v%0d_d_rdv", k), 32'(d_readdatavalid), 32'(vecs[k].edrv));
      chk($sformatf("v%0d_d_rd", k), d_readdata, vecs[k].edrd);
      chk($sformatf("v%0d_d_err", k), 32'(d_error), 32'(vecs[k].eerr));
      chk($sformatf("v%0d_cs", k), 32'(ram_chipselect), 32'(vecs[k].ecs));
      chk($sformatf("v%0d_wr", k), 32'(ram_write), 32'(vecs[k].ewr));
      chk($sformatf("v%0d_dbg", k), 32'(ram_debugaccess), 32'(vecs[k].ewr));
    end

    // contention: data wins 4 cycles, fetch the 5th, repeated
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(1'b1, 16'd5, 1'b1, 1'b0, 16'd6, 4'h0, 32'h0);
      #1;
      chk($sformatf("st%0d_if_wait", c), 32'(if_waitrequest), 32'((c % 5) != 4));
      chk($sformatf("st%0d_d_wait", c), 32'(d_waitrequest), 32'((c % 5) == 4));
      chk($sformatf("st%0d_if_rdv", c), 32'(if_readdatavalid), 32'(c > 0 && ((c - 1) % 5) == 4));
      chk($sformatf("st%0d_d_rdv", c), 32'(d_readdatavalid), 32'(c > 0 && ((c - 1) % 5) != 4));
      if (c > 0 && ((c - 1) % 5) != 4) chk($sformatf("st%0d_d_rd", c), d_readdata, 32'hC0DE0006);
    end
    @(negedge clk);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    #1;
    chk("st_end_if_rdv", 32'(if_readdatavalid), 32'h1);
    chk("st_end_if_rd", if_readdata, 32'hC0DE0005);

    // reset in the cycle of a read accept, with a partly-filled starve count
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1'b1, 16'd7, 1'b1, 1'b0, 16'd8, 4'h0, 32'h0);
    end
    #2;
    reset_n = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    @(negedge clk); #1;
    chk("mr_d_rdv", 32'(d_readdatavalid), 32'h0);
    chk("mr_if_rdv", 32'(if_readdatavalid), 32'h0);
    chk("mr_d_rd", d_readdata, 32'h0);
    chk("mr_d_err", 32'(d_error), 32'h0);
    chk("mr_cs", 32'(ram_chipselect), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(1'b1, 16'd7, 1'b1, 1'b0, 16'd8, 4'h0, 32'h0);
      #1;
      chk($sformatf("mr%0d_if_wait", c), 32'(if_waitrequest), 32'(c != 4));
    end
    @(negedge clk);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    #1;
    chk("mr_end_if_rd", if_readdata, 32'hC0DE0007);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
